// File: rtl/seven_seg_pkg.sv
// Purpose: shared constants and helpers for the seven-segment scan driver.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: segment codes (active-high, bit order {g,f,e,d,c,b,a}),
//           load/commit FSM state type, pow10 and digit-to-segment helpers.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        CS_IDLE    = 2'd0,
        CS_CONVERT = 2'd1,
        CS_COMMIT  = 2'd2
    } conv_state_t;

    // 10^n in 32-bit arithmetic; n is at most 8 so the result always fits.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    // Non-decimal codes map to BLANK so a corrupted digit never lights garbage.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_bin2bcd.sv
// Purpose: sequential double-dabble binary-to-BCD converter (module seg_bin2bcd).
// Latency: VALUE_W cycles from start to final BCD; done is high in the last iteration cycle.
// Backpressure: start is ignored while an iteration is in progress.
// Ports: clock, reset (async, active-high), start/bin (operand capture),
//        bcd (NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]), done.
module seg_bin2bcd
    import seven_seg_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      bin,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0] sh_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;   // iterations still to run; 0 = idle
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [VALUE_W-1:0] sh_nxt;

    // Add-3 correction on every digit >= 5 before the shift, so the digit
    // carries correctly into the next decade after doubling.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_nxt = {adj[BCD_W-2:0], sh_q[VALUE_W-1]};
        sh_nxt  = {sh_q[VALUE_W-2:0], 1'b0};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (cnt_q != '0) begin
            sh_q  <= sh_nxt;
            bcd_q <= bcd_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (start) begin
            sh_q  <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(VALUE_W);
        end
    end

    // Overflowing values simply lose their upper decades here; the caller
    // decides overflow from the binary magnitude and never shows these digits.
    assign bcd  = bcd_q;
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Purpose: signed-decimal multiplexed seven-segment driver with blanking, sign lamp and overflow dashes.
// Latency: busy for VALUE_W+1 cycles after an accepted load; display, sign and overflow update together at the commit edge.
// Backpressure: in_load is ignored (not queued) while out_busy is high; a held in_load re-fires on the first idle cycle.
// Ports: clock, reset (async, active-high), in_value/in_load (value capture), out_busy,
//        out_seven/out_digit_en (scanned digit, registered), out_neg, out_overflow.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    in_value,
    input  logic                  in_load,
    output logic                  out_busy,
    output logic [6:0]            out_seven,
    output logic [NUM_DIGITS-1:0] out_digit_en,
    output logic                  out_neg,
    output logic                  out_overflow
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seven_seg_scan_driver: NUM_DIGITS must be in 1..8");
    end
    if (VALUE_W < 2 || VALUE_W > 32) begin : g_bad_value_w
        $error("seven_seg_scan_driver: VALUE_W must be in 2..32");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seven_seg_scan_driver: REFRESH_DIV must be >= 2");
    end
    if (ACTIVE_LOW < 0 || ACTIVE_LOW > 1) begin : g_bad_active_low
        $error("seven_seg_scan_driver: ACTIVE_LOW must be 0 or 1");
    end

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    // Widened by one bit so a 32-bit magnitude compares without truncation.
    localparam logic [32:0] MAX_SHOWN = 33'(pow10(NUM_DIGITS)) - 33'd1;

    // ---------------- load / convert / commit ----------------
    conv_state_t state_q, state_d;
    logic                    load_acc;
    logic                    commit;
    logic [VALUE_W-1:0]      mag;
    logic                    pend_neg_q;
    logic                    pend_ovf_q;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    conv_done;

    // Two's-complement negate as unsigned: the most negative input maps onto
    // 2^(VALUE_W-1), which is exactly its magnitude.
    assign mag      = in_value[VALUE_W-1] ? (~in_value + VALUE_W'(1)) : in_value;
    assign load_acc = in_load && (state_q == CS_IDLE);

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            CS_IDLE:    if (in_load) state_d = CS_CONVERT;
            CS_CONVERT: if (conv_done) state_d = CS_COMMIT;
            CS_COMMIT: begin
                commit  = 1'b1;
                state_d = CS_IDLE;
            end
            default:    state_d = CS_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= CS_IDLE;
            pend_neg_q <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_acc) begin
                // Zero has a clear MSB, so it can never be captured as negative.
                pend_neg_q <= in_value[VALUE_W-1];
                pend_ovf_q <= (33'(mag) > MAX_SHOWN);
            end
        end
    end

    seg_bin2bcd #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (load_acc),
        .bin   (mag),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // ---------------- display content ----------------
    logic [6:0] new_seg    [NUM_DIGITS];
    logic [6:0] disp_seg_q [NUM_DIGITS];
    logic [6:0] disp_seg_d [NUM_DIGITS];
    logic       disp_neg_q;
    logic       disp_ovf_q;
    logic       seen_nz;
    logic [3:0] dig;

    // Walk from the most significant digit down; a digit is lit once any
    // higher digit was non-zero, and digit 0 is always lit.
    always_comb begin
        seen_nz = 1'b0;
        dig     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            dig        = bcd[4*i +: 4];
            new_seg[i] = SEG_BLANK;
            if (pend_ovf_q) begin
                new_seg[i] = SEG_DASH;
            end else if (seen_nz || (dig != 4'd0) || (i == 0)) begin
                new_seg[i] = digit_to_seg(dig);
                seen_nz    = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_seg_d[i] = commit ? new_seg[i] : disp_seg_q[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                disp_seg_q[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
            end
            disp_neg_q <= 1'b0;
            disp_ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                disp_seg_q[i] <= disp_seg_d[i];
            end
            if (commit) begin
                disp_neg_q <= pend_neg_q;
                disp_ovf_q <= pend_ovf_q;
            end
        end
    end

    // ---------------- scan ----------------
    logic [REF_W-1:0]      ref_q, ref_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  ref_wrap;
    logic [6:0]            seven_q;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    assign ref_wrap = (ref_q == REF_W'(REFRESH_DIV - 1));

    always_comb begin
        ref_d = ref_wrap ? '0 : ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        en_d        = '0;
        en_d[idx_d] = 1'b1;
    end

    // Pin registers load from the next index and next display content, so the
    // segments always match the enabled digit and a commit reaches the pins on
    // the same edge as out_neg / out_overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_q   <= '0;
            idx_q   <= '0;
            seven_q <= SEG_0;
            en_q    <= NUM_DIGITS'(1);
        end else begin
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            seven_q <= disp_seg_d[idx_d];
            en_q    <= en_d;
        end
    end

    // ---------------- pins ----------------
    assign out_busy     = (state_q != CS_IDLE);
    assign out_overflow = disp_ovf_q;
    assign out_seven    = (ACTIVE_LOW != 0) ? ~seven_q    : seven_q;
    assign out_digit_en = (ACTIVE_LOW != 0) ? ~en_q       : en_q;
    assign out_neg      = (ACTIVE_LOW != 0) ? ~disp_neg_q : disp_neg_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Purpose: self-checking bench for seven_seg_scan_driver against a decimal reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] in_value;
    logic        in_load;

    logic       busy4, neg4, ovf4;
    logic [6:0] seven4;
    logic [3:0] en4;
    logic       busy3, neg3, ovf3;
    logic [6:0] seven3;
    logic [2:0] en3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;     // edges since reset release
    int shown = 0;     // value the display is expected to hold
    logic exp_busy = 1'b0;

    logic [6:0] segtab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .VALUE_W(14), .REFRESH_DIV(DIV), .ACTIVE_LOW(0)
    ) u_dut4 (
        .clock(clk), .reset(reset), .in_value(in_value), .in_load(in_load),
        .out_busy(busy4), .out_seven(seven4), .out_digit_en(en4),
        .out_neg(neg4), .out_overflow(ovf4)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(3), .VALUE_W(14), .REFRESH_DIV(DIV), .ACTIVE_LOW(1)
    ) u_dut3 (
        .clock(clk), .reset(reset), .in_value(in_value), .in_load(in_load),
        .out_busy(busy3), .out_seven(seven3), .out_digit_en(en3),
        .out_neg(neg3), .out_overflow(ovf3)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ipow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Expected active-high segments for decimal position pos of val on an nd-digit display.
    function automatic logic [6:0] exp_seg(input int pos, input int val, input int nd);
        int mag = iabs(val);
        int p   = ipow10(pos);
        if (mag > ipow10(nd) - 1) return 7'b1000000;
        if (pos != 0 && mag < p)  return 7'b0000000;
        return segtab[(mag / p) % 10];
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        int i4 = (cyc / DIV) % 4;
        int i3 = (cyc / DIV) % 3;
        logic [6:0] e4  = exp_seg(i4, shown, 4);
        logic [6:0] e3n = ~exp_seg(i3, shown, 3);
        logic [3:0] en4e = 4'(1 << i4);
        logic [2:0] en3e = ~3'(1 << i3);
        logic neg_e = (shown < 0);
        cmp({tag, ".seg4"},  seven4, e4);
        cmp({tag, ".en4"},   en4,    en4e);
        cmp({tag, ".neg4"},  neg4,   neg_e);
        cmp({tag, ".ovf4"},  ovf4,   iabs(shown) > 9999);
        cmp({tag, ".busy4"}, busy4,  exp_busy);
        cmp({tag, ".seg3"},  seven3, e3n);
        cmp({tag, ".en3"},   en3,    en3e);
        cmp({tag, ".neg3"},  neg3,   !neg_e);
        cmp({tag, ".ovf3"},  ovf3,   iabs(shown) > 999);
        cmp({tag, ".busy3"}, busy3,  exp_busy);
    endtask

    // Called right after the accepting edge; checks the busy window and the commit.
    // A second load pulse carrying v2 is offered at iteration intr_at (ignored by design).
    task automatic conv_body(input int v, input int intr_at, input int v2);
        exp_busy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            check_all("conv");
            if (i == intr_at) begin
                in_value = 14'(v2);
                in_load  = 1'b1;
            end
            tick();
            if (i == intr_at) begin
                in_load = 1'b0;
            end
        end
        check_all("conv_end");
        tick();
        shown    = v;
        exp_busy = 1'b0;
        check_all("commit");
    endtask

    task automatic do_load(input int v, input int intr_at, input int v2);
        in_value = 14'(v);
        in_load  = 1'b1;
        tick();
        in_load  = 1'b0;
        conv_body(v, intr_at, v2);
    endtask

    initial begin
        logic [13:0] r;
        int v;
        reset    = 1'b1;
        in_load  = 1'b0;
        in_value = '0;
        repeat (3) tick();
        check_all("reset");
        reset = 1'b0;

        // Idle scan after reset: "0" on digit 0, full rotation of enables.
        for (int i = 0; i < 18; i++) begin
            tick();
            check_all("scan_idle");
        end

        // Directed values: typical, sign, range edges, 3-digit overflow, blanking.
        do_load(1234, -1, 0);
        do_load(-7, -1, 0);
        do_load(8191, -1, 0);
        do_load(-8192, -1, 0);
        do_load(0, -1, 0);
        do_load(-1000, -1, 0);
        do_load(999, -1, 0);
        do_load(-999, -1, 0);
        do_load(100, -1, 0);
        do_load(10, -1, 0);
        do_load(-1, -1, 0);

        // Load while busy is dropped: 5 commits, 9 never appears.
        do_load(5, 1, 9);
        repeat (3) begin tick(); check_all("after_ignored"); end

        // Level-held load: captures 77, then re-fires on the first idle cycle with -77.
        in_value = 14'(77);
        in_load  = 1'b1;
        tick();
        in_value = 14'(-77);
        conv_body(77, -1, 0);
        tick();
        in_load = 1'b0;
        conv_body(-77, -1, 0);

        // Random values with random idle gaps and occasional ignored loads.
        for (int n = 0; n < 30; n++) begin
            r = 14'($urandom_range(0, 16383));
            v = int'($signed(r));
            do_load(v, int'($urandom_range(0, 20)), int'($urandom_range(0, 8191)));
            repeat ($urandom_range(0, 5)) begin tick(); check_all("gap"); end
        end

        // Reset in the middle of converting 42.
        do_load(-3, -1, 0);
        in_value = 14'(42);
        in_load  = 1'b1;
        tick();
        in_load  = 1'b0;
        exp_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin check_all("pre_rst"); tick(); end
        reset = 1'b1;
        #1;
        shown    = 0;
        exp_busy = 1'b0;
        check_all("rst_async");
        repeat (2) begin tick(); check_all("rst_hold"); end
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); check_all("post_rst"); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
